// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : synth_pkg
//  Description : Shared types and helpers for the synth operator datapath.
//                - slot_tag_t     : {valid, voice, oper} tag that travels
//                                   alongside a slot through the operator
//                                   pipeline
//                - sched_state_t  : operator scheduler frame states
//                - SAMPLE_WIDTH   : width of operator results and mixed output
//                - saturate16()   : clamp a wide signed sum to 16 bits
//  Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

    localparam int SAMPLE_WIDTH = 16;

    // Tag fields are sized for up to 256 voices / operators so that the tag
    // type does not depend on the scheduler's parameters; the scheduler
    // zero-extends its narrower indices into these fields.
    localparam int TAG_FIELD_W = 8;

    typedef struct packed {
        logic                   valid;
        logic [TAG_FIELD_W-1:0] voice;
        logic [TAG_FIELD_W-1:0] oper;
    } slot_tag_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_OUTPUT = 3'd3,
        ST_WAIT   = 3'd4
    } sched_state_t;

    // Clamp a sign-extended sum to the signed 16-bit range.
    function automatic logic signed [SAMPLE_WIDTH-1:0] saturate16(input logic signed [31:0] value);
        if (value > 32'sd32767) begin
            return 16'sh7FFF;
        end else if (value < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return value[SAMPLE_WIDTH-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/slot_tag_delay.sv
`default_nettype none
// ============================================================================
//  Module      : slot_tag_delay
//  Description : OP_LATENCY-deep shift register for slot tags. A tag entering
//                on i_Tag appears on o_Tag exactly OP_LATENCY clocks later, in
//                step with the operator result for that slot.
//  Ports       : i_Clock   - clock
//                i_Reset_n - asynchronous active-low reset (clears all stages)
//                i_Tag     - tag of the slot issued this cycle
//                o_Tag     - tag of the slot whose result is due this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module slot_tag_delay
    import synth_pkg::*;
#(
    parameter int OP_LATENCY = 6
) (
    input  logic      i_Clock,
    input  logic      i_Reset_n,
    input  slot_tag_t i_Tag,
    output slot_tag_t o_Tag
);

    slot_tag_t r_stage [OP_LATENCY];

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int i = 0; i < OP_LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_Tag;
            for (int i = 1; i < OP_LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_Tag = r_stage[OP_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/operator_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : operator_scheduler
//  Description : Time-multiplexes one operator pipeline over
//                NUM_VOICES x NUM_OPERATORS slots per output frame, holds the
//                phase-step and key-on register files, and mixes the carrier
//                results of all voices into one saturated 16-bit sample.
//  Ports       : i_Clock, i_Reset_n          - clock, async active-low reset
//                i_RegWrite/Sel/Voice/Operator/Data - host register write
//                o_SlotValid/Voice/Operator  - slot issued this cycle
//                o_PhaseStep, o_KeyOn        - register values for that slot
//                i_OpSampleValid, i_OpSample - operator result stream
//                o_SampleReady, o_Sample     - mixed output, one per frame
//                o_SyncError                 - sticky result/tag misalignment
//  Revision    : 1.0 - initial release
// ============================================================================
module operator_scheduler
    import synth_pkg::*;
#(
    parameter int  NUM_VOICES    = 8,
    parameter int  NUM_OPERATORS = 4,
    parameter int  OP_LATENCY    = 6,
    parameter int  SAMPLE_PERIOD = 256,
    localparam int c_VOICE_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
    localparam int c_OP_W        = $clog2(NUM_OPERATORS)
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    input  logic                 i_RegWrite,
    input  logic                 i_RegSel,
    input  logic [c_VOICE_W-1:0] i_RegVoice,
    input  logic [c_OP_W-1:0]    i_RegOperator,
    input  logic [15:0]          i_RegData,
    output logic                 o_SlotValid,
    output logic [c_VOICE_W-1:0] o_SlotVoice,
    output logic [c_OP_W-1:0]    o_SlotOperator,
    output logic [15:0]          o_PhaseStep,
    output logic                 o_KeyOn,
    input  logic                 i_OpSampleValid,
    input  logic signed [15:0]   i_OpSample,
    output logic                 o_SampleReady,
    output logic signed [15:0]   o_Sample,
    output logic                 o_SyncError
);

    localparam int c_NUM_SLOTS = NUM_VOICES * NUM_OPERATORS;
    localparam int c_ADDR_W    = $clog2(c_NUM_SLOTS);
    localparam int c_IDX_W     = $clog2(c_NUM_SLOTS + 1);
    localparam int c_CNT_W     = $clog2(SAMPLE_PERIOD);
    localparam int c_ACC_W     = SAMPLE_WIDTH + $clog2(NUM_VOICES);

    // ------------------------------------------------------------------
    // Frame counter
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_frame_cnt;
    logic               w_frame_end;

    // Slots are registered, so the first slot is loaded on the edge that
    // wraps the counter; slot k is then visible while the counter reads k.
    assign w_frame_end = (r_frame_cnt == c_CNT_W'(SAMPLE_PERIOD - 1));

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_frame_cnt <= '0;
        end else if (w_frame_end) begin
            r_frame_cnt <= '0;
        end else begin
            r_frame_cnt <= r_frame_cnt + c_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Register files
    // ------------------------------------------------------------------
    logic [15:0]           r_phase_step [c_NUM_SLOTS];
    logic [NUM_VOICES-1:0] r_key_on;
    logic [c_ADDR_W-1:0]   w_wr_addr;

    // Slot address is voice-major: voice * NUM_OPERATORS + operator.
    assign w_wr_addr = c_ADDR_W'((int'(i_RegVoice) << c_OP_W) | int'(i_RegOperator));

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int i = 0; i < c_NUM_SLOTS; i++) begin
                r_phase_step[i] <= '0;
            end
            r_key_on <= '0;
        end else if (i_RegWrite) begin
            if (i_RegSel) begin
                r_key_on[i_RegVoice] <= i_RegData[0];
            end else begin
                r_phase_step[w_wr_addr] <= i_RegData;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scheduler FSM
    // ------------------------------------------------------------------
    sched_state_t r_state;
    sched_state_t w_state_next;
    logic         w_load_slot;
    logic         w_do_output;
    logic         w_last_tag;
    logic [c_IDX_W-1:0] r_slot_idx;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_slot  = 1'b0;
        w_do_output  = 1'b0;
        case (r_state)
            ST_IDLE, ST_WAIT: begin
                if (w_frame_end) begin
                    w_state_next = ST_ISSUE;
                    w_load_slot  = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (r_slot_idx == c_IDX_W'(c_NUM_SLOTS)) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_load_slot = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_last_tag) begin
                    w_state_next = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                w_do_output  = 1'b1;
                w_state_next = ST_WAIT;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Slot issue
    // ------------------------------------------------------------------
    logic [c_ADDR_W-1:0]  w_slot_addr;
    logic [c_VOICE_W-1:0] w_ld_voice;
    logic [c_OP_W-1:0]    w_ld_op;
    logic                 w_phase_hit;
    logic                 w_key_hit;
    logic [15:0]          w_ld_phase;
    logic                 w_ld_key;

    logic                 r_slot_valid;
    logic [c_VOICE_W-1:0] r_slot_voice;
    logic [c_OP_W-1:0]    r_slot_op;
    logic [15:0]          r_phase_out;
    logic                 r_key_out;

    assign w_slot_addr = r_slot_idx[c_ADDR_W-1:0];
    assign w_ld_voice  = c_VOICE_W'(int'(w_slot_addr) >> c_OP_W);
    assign w_ld_op     = w_slot_addr[c_OP_W-1:0];

    // A write sampled on the loading edge is forwarded so that it is visible
    // in the very next cycle. A write during the cycle the slot is already
    // on the outputs cannot change it, so that slot shows the old value.
    assign w_phase_hit = i_RegWrite && !i_RegSel && (w_wr_addr == w_slot_addr);
    assign w_key_hit   = i_RegWrite &&  i_RegSel && (i_RegVoice == w_ld_voice);
    assign w_ld_phase  = w_phase_hit ? i_RegData    : r_phase_step[w_slot_addr];
    assign w_ld_key    = w_key_hit   ? i_RegData[0] : r_key_on[w_ld_voice];

    // ------------------------------------------------------------------
    // Tag pipeline and result collection
    // ------------------------------------------------------------------
    slot_tag_t w_tag_in;
    slot_tag_t w_tag_out;
    logic      w_carrier;
    logic      w_accumulate;
    logic      w_mismatch;

    logic signed [c_ACC_W-1:0] w_sample_ext;
    logic signed [c_ACC_W-1:0] r_acc;
    logic signed [15:0]        r_sample;
    logic                      r_sample_ready;
    logic                      r_sync_error;

    assign w_tag_in.valid = r_slot_valid;
    assign w_tag_in.voice = TAG_FIELD_W'(r_slot_voice);
    assign w_tag_in.oper  = TAG_FIELD_W'(r_slot_op);

    slot_tag_delay #(
        .OP_LATENCY (OP_LATENCY)
    ) u_slot_tag_delay (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Tag     (w_tag_in),
        .o_Tag     (w_tag_out)
    );

    assign w_carrier    = (w_tag_out.oper == TAG_FIELD_W'(NUM_OPERATORS - 1));
    assign w_last_tag   = w_tag_out.valid && w_carrier &&
                          (w_tag_out.voice == TAG_FIELD_W'(NUM_VOICES - 1));
    assign w_mismatch   = (w_tag_out.valid != i_OpSampleValid);
    assign w_accumulate = w_tag_out.valid && i_OpSampleValid && w_carrier;
    assign w_sample_ext = c_ACC_W'(i_OpSample);

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_slot_idx     <= '0;
            r_slot_valid   <= 1'b0;
            r_slot_voice   <= '0;
            r_slot_op      <= '0;
            r_phase_out    <= '0;
            r_key_out      <= 1'b0;
            r_acc          <= '0;
            r_sample       <= '0;
            r_sample_ready <= 1'b0;
            r_sync_error   <= 1'b0;
        end else begin
            r_slot_valid <= w_load_slot;
            if (w_load_slot) begin
                r_slot_voice <= w_ld_voice;
                r_slot_op    <= w_ld_op;
                r_phase_out  <= w_ld_phase;
                r_key_out    <= w_ld_key;
                r_slot_idx   <= r_slot_idx + c_IDX_W'(1);
            end else if (r_state != ST_ISSUE) begin
                r_slot_idx <= '0;
            end

            r_sample_ready <= w_do_output;
            if (w_do_output) begin
                r_sample <= saturate16(32'(r_acc));
                r_acc    <= '0;
            end else if (w_accumulate) begin
                r_acc <= r_acc + w_sample_ext;
            end

            if (w_mismatch) begin
                r_sync_error <= 1'b1;
            end
        end
    end

    assign o_SlotValid    = r_slot_valid;
    assign o_SlotVoice    = r_slot_voice;
    assign o_SlotOperator = r_slot_op;
    assign o_PhaseStep    = r_phase_out;
    assign o_KeyOn        = r_key_out;
    assign o_SampleReady  = r_sample_ready;
    assign o_Sample       = r_sample;
    assign o_SyncError    = r_sync_error;

endmodule
`default_nettype wire

// File: tb/tb_operator_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operator_scheduler
//  Description : Self-checking bench for operator_scheduler. A stub operator
//                answers every issued slot with a chosen sample; the expected
//                mix of each frame is pushed into a queue and a monitor pops
//                it whenever o_SampleReady pulses. Register contents are
//                tracked by a simple array model fed by random host writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operator_scheduler;

    localparam int NV = 8;
    localparam int NO = 4;
    localparam int L  = 6;
    localparam int P  = 256;
    localparam int N  = NV * NO;

    logic               clk;
    logic               rst_n;
    logic               reg_write;
    logic               reg_sel;
    logic [2:0]         reg_voice;
    logic [1:0]         reg_op;
    logic [15:0]        reg_data;
    logic               slot_valid;
    logic [2:0]         slot_voice;
    logic [1:0]         slot_op;
    logic [15:0]        phase_step;
    logic               key_on;
    logic               op_valid;
    logic signed [15:0] op_sample;
    logic               sample_ready;
    logic signed [15:0] sample;
    logic               sync_error;

    operator_scheduler #(
        .NUM_VOICES    (NV),
        .NUM_OPERATORS (NO),
        .OP_LATENCY    (L),
        .SAMPLE_PERIOD (P)
    ) dut (
        .i_Clock         (clk),
        .i_Reset_n       (rst_n),
        .i_RegWrite      (reg_write),
        .i_RegSel        (reg_sel),
        .i_RegVoice      (reg_voice),
        .i_RegOperator   (reg_op),
        .i_RegData       (reg_data),
        .o_SlotValid     (slot_valid),
        .o_SlotVoice     (slot_voice),
        .o_SlotOperator  (slot_op),
        .o_PhaseStep     (phase_step),
        .o_KeyOn         (key_on),
        .i_OpSampleValid (op_valid),
        .i_OpSample      (op_sample),
        .o_SampleReady   (sample_ready),
        .o_Sample        (sample),
        .o_SyncError     (sync_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    longint cyc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- register model ----------------
    logic [15:0] m_phase [NV][NO];
    bit          m_key   [NV];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int v = 0; v < NV; v++) begin
                m_key[v] = 1'b0;
                for (int o = 0; o < NO; o++) m_phase[v][o] = '0;
            end
        end else if (reg_write) begin
            if (reg_sel) m_key[reg_voice] = reg_data[0];
            else         m_phase[reg_voice][reg_op] = reg_data;
        end
    end

    // ---------------- host writer ----------------
    bit wr_rand = 0;
    int dir_req = 0;
    int dir_ack = 0;

    initial begin
        reg_write = 0; reg_sel = 0; reg_voice = 0; reg_op = 0; reg_data = 0;
        forever begin
            @(posedge clk); #1;
            if (dir_req != dir_ack) begin
                reg_write = 1; reg_sel = 0; reg_voice = 3; reg_op = 2; reg_data = 16'h1234;
                dir_ack++;
            end else if (wr_rand && $urandom_range(0, 4) == 0) begin
                reg_write = 1;
                reg_sel   = 1'($urandom_range(0, 1));
                reg_voice = 3'($urandom_range(0, NV - 1));
                reg_op    = 2'($urandom_range(0, NO - 1));
                reg_data  = 16'($urandom);
            end else begin
                reg_write = 0;
            end
        end
    end

    // ---------------- stub operator + scoreboard ----------------
    typedef struct { longint due; int s; } resp_t;
    resp_t pend[$];
    int    exp_q[$];
    int    mode = 0;
    bit    late = 0;

    function automatic int sat(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int gen(input int m, input int op);
        logic [15:0] r;
        bit car = (op == NO - 1);
        case (m)
            1: begin r = 16'($urandom); return int'($signed(r)); end
            2: return car ? 1000 : -5;
            3: return car ? 32767 : -5;
            4: return car ? -32768 : 123;
            5: return int'($urandom_range(0, 8000)) - 4000;
            default: return 0;
        endcase
    endfunction

    initial begin
        op_valid = 0; op_sample = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst_n && pend.size() > 0 && pend[0].due == cyc) begin
                resp_t r;
                r = pend.pop_front();
                op_valid  = 1;
                op_sample = 16'(r.s);
            end else begin
                op_valid  = 0;
                op_sample = 0;
            end
        end
    end

    int     slot_n = 0;
    int     frame_acc = 0;
    int     run = 0;
    longint last_start = 0;
    longint last_ready = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            slot_n = 0; frame_acc = 0; run = 0;
            last_start = 0; last_ready = 0;
            pend.delete();
            exp_q.delete();
        end else begin
            if (slot_valid) begin
                int ev, eo, s;
                ev = slot_n / NO;
                eo = slot_n % NO;
                if (run == 0) begin
                    if (last_start > 0) check("frame_spacing", cyc - last_start, P);
                    last_start = cyc;
                end
                run++;
                check("slot_voice", slot_voice, ev);
                check("slot_op", slot_op, eo);
                check("slot_phase", phase_step, m_phase[ev][eo]);
                check("slot_key", key_on, m_key[ev]);
                s = gen(mode, eo);
                pend.push_back('{cyc + L + (late ? 1 : 0), s});
                if (eo == NO - 1) frame_acc += s;
                slot_n++;
                if (slot_n == N) begin
                    if (!late) exp_q.push_back(sat(frame_acc));
                    frame_acc = 0;
                    slot_n = 0;
                end
            end else if (run > 0) begin
                check("issue_run_length", run, N);
                check("hold_voice", slot_voice, NV - 1);
                check("hold_op", slot_op, NO - 1);
                run = 0;
            end
            if (sample_ready) begin
                if (last_ready > 0) check("ready_period", cyc - last_ready, P);
                last_ready = cyc;
                if (!late) begin
                    check("sync_error_clear", sync_error, 0);
                    if (exp_q.size() == 0) check("ready_without_frame", 1, 0);
                    else check("sample", sample, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    task automatic wait_ready(input int n);
        int seen = 0;
        int budget = n * P + 600;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (sample_ready) seen++;
        end
        if (seen < n) check("wait_ready_timeout", seen, n);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_slot_valid"}, slot_valid, 0);
        check({tag, "_slot_voice"}, slot_voice, 0);
        check({tag, "_slot_op"}, slot_op, 0);
        check({tag, "_phase"}, phase_step, 0);
        check({tag, "_key"}, key_on, 0);
        check({tag, "_ready"}, sample_ready, 0);
        check({tag, "_sample"}, sample, 0);
        check({tag, "_sync"}, sync_error, 0);
    endtask

    initial begin
        longint rel;
        int     off;
        int     budget;

        rst_n = 1;
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #2 check_all_zero("reset");
        @(posedge clk); #1 rst_n = 1;
        rel = cyc;

        // Silent stub: zero samples, first ready one full frame after release.
        mode = 0;
        wait_ready(1);
        check("first_ready_cycle", cyc, rel + P + N + L + 1);
        wait_ready(1);

        // Directed phase-step write, then locate the slot in the next frame.
        dir_req++;
        repeat (3) @(posedge clk);
        budget = 2 * P;
        while (!slot_valid && budget > 0) begin @(negedge clk); budget--; end
        off = 0;
        while (!(slot_valid && slot_voice == 3 && slot_op == 2) && off < 40) begin
            @(negedge clk);
            off++;
        end
        check("v3op2_offset", off, 14);
        check("v3op2_phase", phase_step, 16'h1234);

        // Random writes and random samples.
        wait_ready(1);
        wr_rand = 1;
        mode = 5;
        wait_ready(3);
        mode = 1;
        wait_ready(3);

        // Directed mixes.
        mode = 2;
        wait_ready(1);
        check("mix_8000", sample, 8000);
        mode = 3;
        wait_ready(1);
        check("sat_pos", sample, 32767);
        mode = 4;
        wait_ready(1);
        check("sat_neg", sample, -32768);

        // Late stub: sticky sync error.
        mode = 2;
        late = 1;
        wait_ready(1);
        check("sync_error_set", sync_error, 1);
        wait_ready(1);
        check("sync_error_sticky", sync_error, 1);

        // Reset in the middle of an issue burst.
        budget = 2 * P;
        while (!slot_valid && budget > 0) begin @(negedge clk); budget--; end
        repeat (5) @(negedge clk);
        check("in_issue_before_reset", slot_valid, 1);
        @(posedge clk); #2 rst_n = 0;
        #1 check_all_zero("midreset");
        late = 0;
        mode = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        rel = cyc;
        wait_ready(1);
        check("ready_after_midreset", cyc, rel + P + N + L + 1);
        wait_ready(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
